apb2axi_tag_directory: RTL and testbench
========================================

# apb2axi_tag_directory

Parametrised transaction directory between the APB register file and the AXI transaction manager. It allocates tags from a free list instead of a wrapping pointer and keeps separate in-order pending queues for reads and writes, so one direction never blocks the other. It records completion status per tag and holds each entry until software retires it. Replaces the single-queue directory in the gateway.

## Interface
- TAG_NUM_P, default TAG_NUM: number of directory entries, power of two, 2..64
- TAG_W_P, default $clog2(TAG_NUM_P): tag width
- ADDR_W_P, default AXI_ADDR_W: request address width
- pclk  in  1  clock
- preset  in  1  reset, synchronous, active-high
- commit_valid  in  1  reg file offers a request
- commit_ready  out  1  a free entry exists
- commit_addr / commit_len / commit_size / commit_is_write  in  ADDR_W_P/8/3/1  request fields
- commit_tag  out  TAG_W_P  tag assigned when commit_valid && commit_ready
- rd_pending_valid / wr_pending_valid  out  1  head of the read/write pending queue is valid
- rd_pending_entry / wr_pending_entry  out  directory_entry_t  head entry
- rd_pending_tag / wr_pending_tag  out  TAG_W_P  head tag
- rd_pending_pop / wr_pending_pop  in  1  txn manager takes the head
- cpl_valid  in  1  completion
- cpl_tag  in  TAG_W_P  completion tag
- cpl_error / cpl_resp / cpl_num_beats  in  1/2/8  completion status
- stat_tag  in  TAG_W_P  status query tag
- stat_state / stat_resp / stat_beats  out  dir_state_e/2/8  queried entry status
- retire_valid  in  1  software acknowledges a finished tag
- retire_tag  in  TAG_W_P  tag to free
- free_count  out  TAG_W_P+1  number of EMPTY entries
- proto_err  out  1  sticky illegal-event flag

## Operation
- Entry states: EMPTY → PENDING (commit) → ISSUED (pop) → DONE or ERROR (cpl, chosen by cpl_error) → EMPTY (retire). No other transitions.
- Allocation: commit_tag is the lowest-index EMPTY entry, computed from the registered free vector. On accept, the entry stores the request fields, burst=INCR and tag, and the tag is pushed into the read or write pending FIFO.
- Each pending FIFO has depth TAG_NUM_P and cannot overflow. Its head is reported on *_pending_*. A pop with valid high moves the entry to ISSUED. A pop with valid low is ignored.
- Completion: applies only if the entry is ISSUED. The entry stores cpl_resp and cpl_num_beats. Otherwise the event is ignored and proto_err is set.
- Retire: applies only if the entry is DONE or ERROR. The entry becomes EMPTY and resp/beats are cleared. Otherwise the event is ignored and proto_err is set.
- proto_err is cleared only by reset.

## Timing
- Reset values:
  - All entries EMPTY, fields 0, burst=INCR.
  - Both FIFOs empty; all pending_valid=0.
  - commit_ready=1, commit_tag=0, free_count=TAG_NUM_P, proto_err=0.
  - stat_* reflect entry stat_tag, i.e. EMPTY/0/0.
- Reset asserted mid-operation discards every entry and queue in the same cycle. No partial state survives.
- commit_ready and commit_tag are combinational from registered state. Latency from commit to *_pending_valid is 1 cycle.
- Pop, completion and retire take effect at the next clock edge. stat_* and pending outputs are combinational reads of registered state.
- free_count is registered and updated in the same edge: +1 on retire, −1 on accept, unchanged if both happen.
- Simultaneous events:
  - A tag retired in cycle N is not allocatable until cycle N+1.
  - Commit into an empty queue plus pop in the same cycle: the pop is ignored, because valid was low.
  - Pop and completion for the same tag in the same cycle: the completion is illegal (entry not yet ISSUED), so it is ignored and proto_err is set.
  - Read pop and write pop in the same cycle are independent.
  - Completion and retire on different tags in the same cycle both apply.
- Full condition: commit_ready=0 when free_count=0. commit_valid is then ignored with no state change.

## Structure
- apb2axi_pkg holds:
  - directory_entry_t (tag, addr, len, size, burst, is_write, state, resp, beats)
  - dir_state_e (DIR_ST_EMPTY, PENDING, ISSUED, DONE, ERROR)
  - TAG_NUM and TAG_W
- Sub-module apb2axi_tag_fifo (parametrised depth/width; push, pop, head, valid, pointer wrap). Instantiated twice, once for reads and once for writes.

## Test plan
- Reset, then commit 3 writes and 2 reads interleaved → tags 0..4. wr_pending gives 0,2,4 in order and rd_pending gives 1,3; free_count=11 (TAG_NUM_P=16).
- Fill all 16 entries → commit_ready=0, and a 17th commit_valid causes no change. Retire tag 5 in cycle N → the next commit (cycle N+1) gets tag 5.
- Issue tag 2, complete it with cpl_error=1, resp=2, beats=4 → stat_tag=2 shows ERROR/2/4. Retire it → EMPTY/0/0.
- Complete tag 7 while it is PENDING → state unchanged, proto_err=1. Retire tag 7 while PENDING → ignored.
- Hold rd_pending_pop high with 4 reads queued while writes are also queued → reads issue back-to-back, and wr_pending_valid stays 1 throughout.
- Assert preset with 6 entries in mixed states → next cycle all entries EMPTY, free_count=16, both pending_valid=0, proto_err=0.

Source files
------------

// File: rtl/apb2axi_pkg.sv
// Shared types and defaults for the APB-to-AXI gateway tag directory.
// The directory entry layout is also what the transaction manager sees at each pending-queue head.
package apb2axi_pkg;

  localparam int TAG_NUM    = 16;
  localparam int TAG_W      = $clog2(TAG_NUM);
  localparam int AXI_ADDR_W = 32;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    DIR_ST_EMPTY,
    DIR_ST_PENDING,
    DIR_ST_ISSUED,
    DIR_ST_DONE,
    DIR_ST_ERROR
  } dir_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  is_write;
    dir_state_e            state;
    logic [1:0]            resp;
    logic [7:0]            beats;
  } directory_entry_t;

  // A free slot still reports INCR so the head entry is always a legal AXI burst.
  function automatic directory_entry_t empty_entry();
    directory_entry_t e;
    e       = '0;
    e.burst = AXI_BURST_INCR;
    e.state = DIR_ST_EMPTY;
    return e;
  endfunction

endpackage

// File: rtl/apb2axi_tag_directory_if.sv
// Bus bundle between the register file / transaction manager (master) and the tag directory (slave).
interface apb2axi_tag_directory_if
  import apb2axi_pkg::*;
#(
  parameter int TAG_W_P  = TAG_W,
  parameter int ADDR_W_P = AXI_ADDR_W
) ();

  logic                commit_valid;
  logic                commit_ready;
  logic [ADDR_W_P-1:0] commit_addr;
  logic [7:0]          commit_len;
  logic [2:0]          commit_size;
  logic                commit_is_write;
  logic [TAG_W_P-1:0]  commit_tag;

  logic                rd_pending_valid;
  directory_entry_t    rd_pending_entry;
  logic [TAG_W_P-1:0]  rd_pending_tag;
  logic                rd_pending_pop;

  logic                wr_pending_valid;
  directory_entry_t    wr_pending_entry;
  logic [TAG_W_P-1:0]  wr_pending_tag;
  logic                wr_pending_pop;

  logic                cpl_valid;
  logic [TAG_W_P-1:0]  cpl_tag;
  logic                cpl_error;
  logic [1:0]          cpl_resp;
  logic [7:0]          cpl_num_beats;

  logic [TAG_W_P-1:0]  stat_tag;
  dir_state_e          stat_state;
  logic [1:0]          stat_resp;
  logic [7:0]          stat_beats;

  logic                retire_valid;
  logic [TAG_W_P-1:0]  retire_tag;

  logic [TAG_W_P:0]    free_count;
  logic                proto_err;

  modport slave (
    input  commit_valid, commit_addr, commit_len, commit_size, commit_is_write,
    output commit_ready, commit_tag,
    output rd_pending_valid, rd_pending_entry, rd_pending_tag,
    input  rd_pending_pop,
    output wr_pending_valid, wr_pending_entry, wr_pending_tag,
    input  wr_pending_pop,
    input  cpl_valid, cpl_tag, cpl_error, cpl_resp, cpl_num_beats,
    input  stat_tag,
    output stat_state, stat_resp, stat_beats,
    input  retire_valid, retire_tag,
    output free_count, proto_err
  );

  modport master (
    output commit_valid, commit_addr, commit_len, commit_size, commit_is_write,
    input  commit_ready, commit_tag,
    input  rd_pending_valid, rd_pending_entry, rd_pending_tag,
    output rd_pending_pop,
    input  wr_pending_valid, wr_pending_entry, wr_pending_tag,
    output wr_pending_pop,
    output cpl_valid, cpl_tag, cpl_error, cpl_resp, cpl_num_beats,
    output stat_tag,
    input  stat_state, stat_resp, stat_beats,
    output retire_valid, retire_tag,
    input  free_count, proto_err
  );

endinterface

// File: rtl/apb2axi_tag_fifo.sv
// In-order tag queue used for one direction of pending transactions.
// Pops are ignored while empty; pushes are dropped only when full and not popping.
module apb2axi_tag_fifo #(
  parameter int DEPTH_P = 16,
  parameter int WIDTH_P = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH_P-1:0] push_data,
  input  logic               pop,
  output logic [WIDTH_P-1:0] head,
  output logic               valid
);

  localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int CNT_W = $clog2(DEPTH_P + 1);

  logic [WIDTH_P-1:0] mem [DEPTH_P];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH_P - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CNT_W'(DEPTH_P)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/apb2axi_tag_directory.sv
// Transaction directory: free-list tag allocation, separate read/write pending queues,
// per-tag completion status held until software retires the tag.
module apb2axi_tag_directory
  import apb2axi_pkg::*;
#(
  parameter int TAG_NUM_P = TAG_NUM,
  parameter int TAG_W_P   = $clog2(TAG_NUM_P),
  parameter int ADDR_W_P  = AXI_ADDR_W
) (
  input  logic                    pclk,
  input  logic                    preset,
  apb2axi_tag_directory_if.slave  bus
);

  localparam int CNT_W = TAG_W_P + 1;

  directory_entry_t     entries [TAG_NUM_P];
  logic [TAG_NUM_P-1:0] free_vec;
  logic [TAG_W_P-1:0]   alloc_tag;
  logic                 commit_ready;
  logic                 accept;

  logic [TAG_W_P-1:0]   rd_head;
  logic [TAG_W_P-1:0]   wr_head;
  logic                 rd_valid;
  logic                 wr_valid;
  logic                 rd_pop;
  logic                 wr_pop;

  dir_state_e           cpl_state;
  dir_state_e           retire_state;
  logic                 cpl_ok;
  logic                 retire_ok;
  logic                 cpl_bad;
  logic                 retire_bad;

  logic [CNT_W-1:0]     free_count_q;
  logic                 proto_err_q;

  // Lowest-index EMPTY entry wins; a slot retired this cycle only shows up after the edge.
  always_comb begin
    free_vec  = '0;
    alloc_tag = '0;
    for (int i = 0; i < TAG_NUM_P; i++) begin
      free_vec[i] = (entries[i].state == DIR_ST_EMPTY);
    end
    for (int i = TAG_NUM_P - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_tag = TAG_W_P'(i);
      end
    end
  end

  assign commit_ready = |free_vec;
  assign accept       = bus.commit_valid && commit_ready;

  apb2axi_tag_fifo #(
    .DEPTH_P (TAG_NUM_P),
    .WIDTH_P (TAG_W_P)
  ) u_rd_fifo (
    .clk       (pclk),
    .rst       (preset),
    .push      (accept && !bus.commit_is_write),
    .push_data (alloc_tag),
    .pop       (bus.rd_pending_pop),
    .head      (rd_head),
    .valid     (rd_valid)
  );

  apb2axi_tag_fifo #(
    .DEPTH_P (TAG_NUM_P),
    .WIDTH_P (TAG_W_P)
  ) u_wr_fifo (
    .clk       (pclk),
    .rst       (preset),
    .push      (accept && bus.commit_is_write),
    .push_data (alloc_tag),
    .pop       (bus.wr_pending_pop),
    .head      (wr_head),
    .valid     (wr_valid)
  );

  assign rd_pop = bus.rd_pending_pop && rd_valid;
  assign wr_pop = bus.wr_pending_pop && wr_valid;

  // Legality is judged on the registered state, so a same-cycle pop does not make a completion legal.
  assign cpl_state    = entries[bus.cpl_tag].state;
  assign retire_state = entries[bus.retire_tag].state;
  assign cpl_ok       = bus.cpl_valid && (cpl_state == DIR_ST_ISSUED);
  assign retire_ok    = bus.retire_valid &&
                        ((retire_state == DIR_ST_DONE) || (retire_state == DIR_ST_ERROR));
  assign cpl_bad      = bus.cpl_valid && !cpl_ok;
  assign retire_bad   = bus.retire_valid && !retire_ok;

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < TAG_NUM_P; i++) begin
        entries[i] <= empty_entry();
      end
      free_count_q <= CNT_W'(TAG_NUM_P);
      proto_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < TAG_NUM_P; i++) begin
        if (accept && (alloc_tag == TAG_W_P'(i))) begin
          entries[i].tag      <= TAG_W'(i);
          entries[i].addr     <= AXI_ADDR_W'(bus.commit_addr);
          entries[i].len      <= bus.commit_len;
          entries[i].size     <= bus.commit_size;
          entries[i].burst    <= AXI_BURST_INCR;
          entries[i].is_write <= bus.commit_is_write;
          entries[i].state    <= DIR_ST_PENDING;
          entries[i].resp     <= '0;
          entries[i].beats    <= '0;
        end
        if ((rd_pop && (rd_head == TAG_W_P'(i))) || (wr_pop && (wr_head == TAG_W_P'(i)))) begin
          entries[i].state <= DIR_ST_ISSUED;
        end
        if (cpl_ok && (bus.cpl_tag == TAG_W_P'(i))) begin
          entries[i].state <= bus.cpl_error ? DIR_ST_ERROR : DIR_ST_DONE;
          entries[i].resp  <= bus.cpl_resp;
          entries[i].beats <= bus.cpl_num_beats;
        end
        if (retire_ok && (bus.retire_tag == TAG_W_P'(i))) begin
          entries[i].state <= DIR_ST_EMPTY;
          entries[i].resp  <= '0;
          entries[i].beats <= '0;
        end
      end

      if (cpl_bad || retire_bad) begin
        proto_err_q <= 1'b1;
      end

      if (accept && !retire_ok) begin
        free_count_q <= free_count_q - CNT_W'(1);
      end else if (retire_ok && !accept) begin
        free_count_q <= free_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.commit_ready     = commit_ready;
  assign bus.commit_tag       = alloc_tag;

  assign bus.rd_pending_valid = rd_valid;
  assign bus.rd_pending_tag   = rd_head;
  assign bus.rd_pending_entry = entries[rd_head];
  assign bus.wr_pending_valid = wr_valid;
  assign bus.wr_pending_tag   = wr_head;
  assign bus.wr_pending_entry = entries[wr_head];

  assign bus.stat_state       = entries[bus.stat_tag].state;
  assign bus.stat_resp        = entries[bus.stat_tag].resp;
  assign bus.stat_beats       = entries[bus.stat_tag].beats;

  assign bus.free_count       = free_count_q;
  assign bus.proto_err        = proto_err_q;

endmodule

// File: tb/tb_apb2axi_tag_directory.sv
// Self-checking bench for apb2axi_tag_directory with 16 entries.
// A small model tracks entry states and scoreboard queues hold the expected pending-head order.
module tb_apb2axi_tag_directory;
  import apb2axi_pkg::*;

  logic pclk = 1'b0;
  logic preset;

  int tests_run    = 0;
  int tests_failed = 0;

  apb2axi_tag_directory_if #(.TAG_W_P(4), .ADDR_W_P(32)) bus ();

  apb2axi_tag_directory #(
    .TAG_NUM_P (16),
    .TAG_W_P   (4),
    .ADDR_W_P  (32)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  dir_state_e  m_state [16];
  logic [1:0]  m_resp  [16];
  logic [7:0]  m_beats [16];
  logic [31:0] m_addr  [16];
  int          m_free;
  bit          m_err;
  logic [3:0]  q_rd [$];
  logic [3:0]  q_wr [$];

  function automatic logic [3:0] m_lowest();
    for (int i = 0; i < 16; i++) begin
      if (m_state[i] == DIR_ST_EMPTY) return 4'(i);
    end
    return 4'd0;
  endfunction

  task automatic clear_inputs();
    bus.commit_valid    = 1'b0;
    bus.commit_addr     = '0;
    bus.commit_len      = '0;
    bus.commit_size     = '0;
    bus.commit_is_write = 1'b0;
    bus.rd_pending_pop  = 1'b0;
    bus.wr_pending_pop  = 1'b0;
    bus.cpl_valid       = 1'b0;
    bus.cpl_tag         = '0;
    bus.cpl_error       = 1'b0;
    bus.cpl_resp        = '0;
    bus.cpl_num_beats   = '0;
    bus.stat_tag        = '0;
    bus.retire_valid    = 1'b0;
    bus.retire_tag      = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_state[i] = DIR_ST_EMPTY;
      m_resp[i]  = '0;
      m_beats[i] = '0;
      m_addr[i]  = '0;
    end
    m_free = 16;
    m_err  = 1'b0;
    q_rd.delete();
    q_wr.delete();
  endtask

  task automatic do_reset();
    @(negedge pclk);
    clear_inputs();
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    model_reset();
  endtask

  task automatic do_commit(input bit w, input logic [31:0] a,
                           output logic [3:0] obs, output logic [3:0] exp, output bit acc);
    @(negedge pclk);
    acc = (m_free != 0);
    exp = m_lowest();
    bus.commit_valid    = 1'b1;
    bus.commit_addr     = a;
    bus.commit_len      = a[7:0];
    bus.commit_size     = 3'd2;
    bus.commit_is_write = w;
    obs = bus.commit_tag;
    @(posedge pclk); #1;
    bus.commit_valid = 1'b0;
    if (acc) begin
      m_state[exp] = DIR_ST_PENDING;
      m_addr[exp]  = a;
      m_free--;
      if (w) q_wr.push_back(exp);
      else   q_rd.push_back(exp);
    end
  endtask

  task automatic do_pop(input bit w, output bit ov, output logic [3:0] ot, output logic [3:0] et,
                        output logic [31:0] oa, output logic [31:0] ea);
    bit had;
    @(negedge pclk);
    ov  = w ? bus.wr_pending_valid : bus.rd_pending_valid;
    ot  = w ? bus.wr_pending_tag : bus.rd_pending_tag;
    oa  = w ? bus.wr_pending_entry.addr : bus.rd_pending_entry.addr;
    et  = 4'hf;
    ea  = '0;
    had = 1'b0;
    if (w && q_wr.size() > 0) begin
      et = q_wr.pop_front(); had = 1'b1;
    end else if (!w && q_rd.size() > 0) begin
      et = q_rd.pop_front(); had = 1'b1;
    end
    if (had) ea = m_addr[et];
    if (w) bus.wr_pending_pop = 1'b1;
    else   bus.rd_pending_pop = 1'b1;
    @(posedge pclk); #1;
    bus.wr_pending_pop = 1'b0;
    bus.rd_pending_pop = 1'b0;
    if (had) m_state[et] = DIR_ST_ISSUED;
  endtask

  task automatic model_cpl(input logic [3:0] t, input bit err, input logic [1:0] r, input logic [7:0] b);
    if (m_state[t] == DIR_ST_ISSUED) begin
      m_state[t] = err ? DIR_ST_ERROR : DIR_ST_DONE;
      m_resp[t]  = r;
      m_beats[t] = b;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_retire(input logic [3:0] t);
    if (m_state[t] == DIR_ST_DONE || m_state[t] == DIR_ST_ERROR) begin
      m_state[t] = DIR_ST_EMPTY;
      m_resp[t]  = '0;
      m_beats[t] = '0;
      m_free++;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic do_cpl(input logic [3:0] t, input bit err, input logic [1:0] r, input logic [7:0] b);
    @(negedge pclk);
    bus.cpl_valid = 1'b1; bus.cpl_tag = t; bus.cpl_error = err;
    bus.cpl_resp = r; bus.cpl_num_beats = b;
    @(posedge pclk); #1;
    bus.cpl_valid = 1'b0;
    model_cpl(t, err, r, b);
  endtask

  task automatic do_retire(input logic [3:0] t);
    @(negedge pclk);
    bus.retire_valid = 1'b1; bus.retire_tag = t;
    @(posedge pclk); #1;
    bus.retire_valid = 1'b0;
    model_retire(t);
  endtask

  task automatic peek(input logic [3:0] t);
    bus.stat_tag = t;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    peek(4'd0);
    tests_run++;
    if (bus.commit_ready !== 1'b1 || bus.commit_tag !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_commit: ready=%0d tag=%0d expected ready=1 tag=0", bus.commit_ready, bus.commit_tag);
    end
    tests_run++;
    if (bus.free_count !== 5'd16 || bus.proto_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counts: free_count=%0d proto_err=%0d expected 16/0", bus.free_count, bus.proto_err);
    end
    tests_run++;
    if (bus.rd_pending_valid !== 1'b0 || bus.wr_pending_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pending: rd_valid=%0d wr_valid=%0d expected 0/0", bus.rd_pending_valid, bus.wr_pending_valid);
    end
    tests_run++;
    if (bus.stat_state !== DIR_ST_EMPTY || bus.stat_resp !== 2'd0 || bus.stat_beats !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stat: state=%0d resp=%0d beats=%0d expected EMPTY/0/0", bus.stat_state, bus.stat_resp, bus.stat_beats);
    end
  endtask

  task automatic test_alloc_order();
    logic [3:0]  obs, exp;
    bit          acc, ov;
    logic [31:0] oa, ea;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_commit((i % 2) == 0, 32'h1000 + 32'(i) * 32'h40, obs, exp, acc);
      tests_run++;
      if (obs !== 4'(i)) begin
        tests_failed++;
        $display("[TB] FAIL alloc_tag_%0d: got %0d expected %0d", i, obs, i);
      end
    end
    #1;
    tests_run++;
    if (bus.free_count !== 5'd11) begin
      tests_failed++;
      $display("[TB] FAIL alloc_free_count: got %0d expected 11", bus.free_count);
    end
    tests_run++;
    if (bus.wr_pending_entry.burst !== AXI_BURST_INCR || bus.wr_pending_entry.is_write !== 1'b1 ||
        bus.wr_pending_entry.state !== DIR_ST_PENDING || bus.rd_pending_entry.is_write !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL alloc_head_fields: burst=%0d wr_is_write=%0d state=%0d rd_is_write=%0d expected 1/1/PENDING/0",
               bus.wr_pending_entry.burst, bus.wr_pending_entry.is_write, bus.wr_pending_entry.state,
               bus.rd_pending_entry.is_write);
    end
    for (int k = 0; k < 5; k++) begin
      do_pop(k < 3, ov, obs, exp, oa, ea);
      tests_run++;
      if (ov !== 1'b1 || obs !== exp || oa !== ea) begin
        tests_failed++;
        $display("[TB] FAIL alloc_pop_%0d: valid=%0d tag=%0d addr=%h expected 1/%0d/%h", k, ov, obs, oa, exp, ea);
      end
    end
  endtask

  task automatic test_full_and_retire();
    logic [3:0]  obs, exp;
    bit          acc, ov, ready_n;
    logic [31:0] oa, ea;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_commit((i % 2) == 0, 32'h2000 + 32'(i), obs, exp, acc);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL fill_tag_%0d: got %0d expected %0d", i, obs, exp);
      end
    end
    #1;
    tests_run++;
    if (bus.commit_ready !== 1'b0 || bus.free_count !== 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL full_state: ready=%0d free_count=%0d expected 0/0", bus.commit_ready, bus.free_count);
    end
    do_commit(1'b1, 32'hdead_0000, obs, exp, acc);
    tests_run++;
    if (bus.free_count !== 5'd0 || bus.wr_pending_tag !== q_wr[0] || bus.rd_pending_tag !== q_rd[0]) begin
      tests_failed++;
      $display("[TB] FAIL full_ignore: free_count=%0d wr_head=%0d rd_head=%0d expected 0/%0d/%0d",
               bus.free_count, bus.wr_pending_tag, bus.rd_pending_tag, q_wr[0], q_rd[0]);
    end
    for (int k = 0; k < 3; k++) begin
      do_pop(1'b0, ov, obs, exp, oa, ea);
      tests_run++;
      if (ov !== 1'b1 || obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL full_rd_pop_%0d: valid=%0d tag=%0d expected 1/%0d", k, ov, obs, exp);
      end
    end
    do_cpl(4'd5, 1'b0, 2'd0, 8'd8);
    @(negedge pclk);
    bus.retire_valid = 1'b1; bus.retire_tag = 4'd5;
    bus.commit_valid = 1'b1; bus.commit_is_write = 1'b1; bus.commit_addr = 32'h3000;
    ready_n = bus.commit_ready;
    @(posedge pclk); #1;
    bus.retire_valid = 1'b0; bus.commit_valid = 1'b0;
    model_retire(4'd5);
    tests_run++;
    if (ready_n !== 1'b0 || bus.free_count !== 5'd1) begin
      tests_failed++;
      $display("[TB] FAIL retire_cycle_n: ready=%0d free_count=%0d expected 0/1", ready_n, bus.free_count);
    end
    do_commit(1'b1, 32'h3000, obs, exp, acc);
    tests_run++;
    if (obs !== 4'd5 || bus.free_count !== 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL retire_realloc: tag=%0d free_count=%0d expected 5/0", obs, bus.free_count);
    end
  endtask

  task automatic test_error_completion();
    logic [3:0]  obs, exp;
    bit          acc, ov;
    logic [31:0] oa, ea;
    do_reset();
    do_commit(1'b1, 32'h100, obs, exp, acc);
    do_commit(1'b0, 32'h200, obs, exp, acc);
    do_commit(1'b1, 32'h300, obs, exp, acc);
    do_pop(1'b1, ov, obs, exp, oa, ea);
    do_pop(1'b1, ov, obs, exp, oa, ea);
    tests_run++;
    if (ov !== 1'b1 || obs !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL err_issue: valid=%0d tag=%0d expected 1/2", ov, obs);
    end
    do_cpl(4'd2, 1'b1, 2'd2, 8'd4);
    peek(4'd2);
    tests_run++;
    if (bus.stat_state !== DIR_ST_ERROR || bus.stat_resp !== 2'd2 || bus.stat_beats !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL err_status: state=%0d resp=%0d beats=%0d expected ERROR/2/4", bus.stat_state, bus.stat_resp, bus.stat_beats);
    end
    @(negedge pclk);
    bus.retire_valid = 1'b1; bus.retire_tag = 4'd2;
    bus.cpl_valid = 1'b1; bus.cpl_tag = 4'd0; bus.cpl_error = 1'b0; bus.cpl_resp = 2'd0; bus.cpl_num_beats = 8'd8;
    @(posedge pclk); #1;
    bus.retire_valid = 1'b0; bus.cpl_valid = 1'b0;
    model_retire(4'd2);
    model_cpl(4'd0, 1'b0, 2'd0, 8'd8);
    peek(4'd2);
    tests_run++;
    if (bus.stat_state !== DIR_ST_EMPTY || bus.stat_resp !== 2'd0 || bus.stat_beats !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL err_retire: state=%0d resp=%0d beats=%0d expected EMPTY/0/0", bus.stat_state, bus.stat_resp, bus.stat_beats);
    end
    peek(4'd0);
    tests_run++;
    if (bus.stat_state !== DIR_ST_DONE || bus.stat_beats !== 8'd8 || bus.proto_err !== 1'b0 || bus.free_count !== 5'd14) begin
      tests_failed++;
      $display("[TB] FAIL cpl_with_retire: state=%0d beats=%0d proto_err=%0d free_count=%0d expected DONE/8/0/14",
               bus.stat_state, bus.stat_beats, bus.proto_err, bus.free_count);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] obs, exp;
    bit         acc;
    do_reset();
    @(negedge pclk);
    exp = m_lowest();
    bus.commit_valid = 1'b1; bus.commit_is_write = 1'b1; bus.commit_addr = 32'h40;
    bus.wr_pending_pop = 1'b1;
    @(posedge pclk); #1;
    bus.commit_valid = 1'b0; bus.wr_pending_pop = 1'b0;
    m_state[exp] = DIR_ST_PENDING; m_free--; q_wr.push_back(exp);
    peek(exp);
    tests_run++;
    if (bus.wr_pending_valid !== 1'b1 || bus.stat_state !== DIR_ST_PENDING) begin
      tests_failed++;
      $display("[TB] FAIL commit_pop_empty: wr_valid=%0d state=%0d expected 1/PENDING", bus.wr_pending_valid, bus.stat_state);
    end
    do_commit(1'b0, 32'h80, obs, exp, acc);
    @(negedge pclk);
    bus.rd_pending_pop = 1'b1; bus.wr_pending_pop = 1'b1;
    bus.cpl_valid = 1'b1; bus.cpl_tag = 4'd0; bus.cpl_error = 1'b0; bus.cpl_num_beats = 8'd1;
    @(posedge pclk); #1;
    bus.rd_pending_pop = 1'b0; bus.wr_pending_pop = 1'b0; bus.cpl_valid = 1'b0;
    model_cpl(4'd0, 1'b0, 2'd0, 8'd1);
    m_state[q_wr.pop_front()] = DIR_ST_ISSUED;
    m_state[q_rd.pop_front()] = DIR_ST_ISSUED;
    peek(4'd0);
    tests_run++;
    if (bus.stat_state !== DIR_ST_ISSUED || bus.stat_beats !== 8'd0 || bus.proto_err !== m_err) begin
      tests_failed++;
      $display("[TB] FAIL pop_cpl_same: state=%0d beats=%0d proto_err=%0d expected ISSUED/0/%0d",
               bus.stat_state, bus.stat_beats, bus.proto_err, m_err);
    end
    peek(4'd1);
    tests_run++;
    if (bus.stat_state !== DIR_ST_ISSUED || bus.rd_pending_valid !== 1'b0 || bus.wr_pending_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL dual_pop: state=%0d rd_valid=%0d wr_valid=%0d expected ISSUED/0/0",
               bus.stat_state, bus.rd_pending_valid, bus.wr_pending_valid);
    end
  endtask

  task automatic test_illegal_events();
    logic [3:0] obs, exp;
    bit         acc;
    do_reset();
    for (int i = 0; i < 8; i++) do_commit(1'b1, 32'h500 + 32'(i), obs, exp, acc);
    do_cpl(4'd7, 1'b0, 2'd1, 8'd3);
    peek(4'd7);
    tests_run++;
    if (bus.stat_state !== DIR_ST_PENDING || bus.stat_resp !== 2'd0 || bus.proto_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL cpl_pending: state=%0d resp=%0d proto_err=%0d expected PENDING/0/1",
               bus.stat_state, bus.stat_resp, bus.proto_err);
    end
    do_retire(4'd7);
    peek(4'd7);
    tests_run++;
    if (bus.stat_state !== DIR_ST_PENDING || bus.free_count !== 5'd8 || bus.proto_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL retire_pending: state=%0d free_count=%0d proto_err=%0d expected PENDING/8/1",
               bus.stat_state, bus.free_count, bus.proto_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    bit         acc;
    bit         bad;
    do_reset();
    do_commit(1'b0, 32'h10, obs, exp, acc);
    do_commit(1'b1, 32'h20, obs, exp, acc);
    do_commit(1'b0, 32'h30, obs, exp, acc);
    do_commit(1'b1, 32'h40, obs, exp, acc);
    do_commit(1'b0, 32'h50, obs, exp, acc);
    do_commit(1'b0, 32'h60, obs, exp, acc);
    @(negedge pclk);
    bus.rd_pending_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = (q_rd.size() > 0) ? q_rd.pop_front() : 4'hf;
      bad = (bus.rd_pending_valid !== 1'b1) || (bus.rd_pending_tag !== exp) || (bus.wr_pending_valid !== 1'b1);
      tests_run++;
      if (bad) begin
        tests_failed++;
        $display("[TB] FAIL b2b_read_%0d: rd_valid=%0d rd_tag=%0d wr_valid=%0d expected 1/%0d/1",
                 k, bus.rd_pending_valid, bus.rd_pending_tag, bus.wr_pending_valid, exp);
      end
      m_state[exp] = DIR_ST_ISSUED;
      @(negedge pclk);
    end
    bus.rd_pending_pop = 1'b0;
    peek(4'd5);
    tests_run++;
    if (bus.rd_pending_valid !== 1'b0 || bus.wr_pending_valid !== 1'b1 || bus.stat_state !== DIR_ST_ISSUED) begin
      tests_failed++;
      $display("[TB] FAIL b2b_after: rd_valid=%0d wr_valid=%0d tag5_state=%0d expected 0/1/ISSUED",
               bus.rd_pending_valid, bus.wr_pending_valid, bus.stat_state);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0]  obs, exp;
    bit          acc, ov;
    logic [31:0] oa, ea;
    do_reset();
    for (int i = 0; i < 6; i++) do_commit((i % 2) == 0, 32'h700 + 32'(i), obs, exp, acc);
    do_pop(1'b1, ov, obs, exp, oa, ea);
    do_cpl(4'd0, 1'b0, 2'd0, 8'd2);
    do_pop(1'b0, ov, obs, exp, oa, ea);
    do_cpl(4'd3, 1'b0, 2'd0, 8'd2);
    tests_run++;
    if (bus.proto_err !== 1'b1 || bus.free_count !== 5'd10) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset: proto_err=%0d free_count=%0d expected 1/10", bus.proto_err, bus.free_count);
    end
    @(negedge pclk);
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    model_reset();
    tests_run++;
    if (bus.free_count !== 5'd16 || bus.proto_err !== 1'b0 || bus.rd_pending_valid !== 1'b0 ||
        bus.wr_pending_valid !== 1'b0 || bus.commit_tag !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: free_count=%0d proto_err=%0d rd_valid=%0d wr_valid=%0d tag=%0d expected 16/0/0/0/0",
               bus.free_count, bus.proto_err, bus.rd_pending_valid, bus.wr_pending_valid, bus.commit_tag);
    end
    for (int t = 0; t < 6; t++) begin
      peek(4'(t));
      tests_run++;
      if (bus.stat_state !== DIR_ST_EMPTY || bus.stat_beats !== 8'd0) begin
        tests_failed++;
        $display("[TB] FAIL mid_reset_tag_%0d: state=%0d beats=%0d expected EMPTY/0", t, bus.stat_state, bus.stat_beats);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    preset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_alloc_order();
    test_full_and_retire();
    test_error_completion();
    test_simultaneous();
    test_illegal_events();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
